// File: rtl/breath_pkg.sv
// breath_pkg: shared types, default constants and the duty mapping function
// for the LED breathing ramp (breath_ramp and its tick_gen sub-module).
//
// Contents:
//   state_t         ramp FSM states HOLD_LO, RISE, HOLD_HI, FALL
//   DEF_PRESC       default clock cycles per base tick (1 kHz at 50 MHz)
//   DEF_STEP        default level increment/decrement per step event
//   DEF_HOLD_STEPS  default step events spent in each hold state
//   gamma_map()     level -> duty mapping
//
// Configuration macro: BREATH_GAMMA_EN
//   defined   : gamma_map(l) = (l*l + l) >> 8 (perceptually linear fade)
//   undefined : gamma_map(l) = l, no multiplier is built
`timescale 1ns/1ps
package breath_pkg;

  typedef enum logic [1:0] {
    HOLD_LO = 2'd0,
    RISE    = 2'd1,
    HOLD_HI = 2'd2,
    FALL    = 2'd3
  } state_t;

  localparam int DEF_PRESC      = 50000;
  localparam int DEF_STEP       = 1;
  localparam int DEF_HOLD_STEPS = 16;

  function automatic logic [7:0] gamma_map(input logic [7:0] lvl);
`ifdef BREATH_GAMMA_EN
    logic [15:0] sq;
    // The "+ lvl" term makes 255 map exactly to 255: 255*256 >> 8 = 255.
    sq = ({8'd0, lvl} * {8'd0, lvl}) + {8'd0, lvl};
    return sq[15:8];
`else
    return lvl;
`endif
  endfunction

endpackage

// File: rtl/breath_ramp_tick_gen.sv
// tick_gen: base-tick prescaler followed by a rate counter; emits one step
// pulse every Rate x PRESC clock cycles while run is high.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   run       in   Enable & (Rate != 0); low freezes both counters
//   Rate      in   base ticks per step event
//   step      out  one-cycle step pulse (combinational from the counters)
//
// No configuration macros affect this module.
`timescale 1ns/1ps
module tick_gen
  import breath_pkg::*;
#(
  parameter int PRESC = DEF_PRESC
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       run,
  input  logic [7:0] Rate,
  output logic       step
);

  localparam int            PW         = $clog2(PRESC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_cnt;
  logic [7:0]    rate_cnt;
  logic [8:0]    rate_inc;
  logic          tick;

  assign tick     = run && (presc_cnt == PRESC_LAST);
  assign rate_inc = {1'b0, rate_cnt} + 9'd1;
  // ">=" rather than "==" so that lowering Rate below the current count
  // still produces a step on the very next tick.
  assign step     = tick && (rate_inc >= {1'b0, Rate});

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_cnt <= '0;
      rate_cnt  <= '0;
    end else if (run) begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      if (step)
        rate_cnt <= '0;
      else if (tick)
        rate_cnt <= rate_inc[7:0];
    end
  end

endmodule

// File: rtl/breath_ramp.sv
// breath_ramp: generates the 8-bit duty value for the downstream PWM stage
// as a rise / hold / fall / hold "breathing" triangle. The level moves by
// STEP on each step event from tick_gen and saturates at 0 and 255. Duty is
// reloaded only in the cycle PwmCount == 8'hFF so the PWM never sees a
// change in the middle of its period.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   Enable    in   high = ramp runs, low = everything but Duty reload frozen
//   Rate[7:0] in   base ticks per step event, 0 = frozen
//   PwmCount  in   free-running counter of the PWM stage
//   Duty      out  registered duty value for the PWM stage
//   Dir       out  1 in RISE/HOLD_HI, 0 in FALL/HOLD_LO
//   Peak      out  one-cycle pulse on the first cycle in HOLD_HI
//
// Configuration macro: BREATH_GAMMA_EN selects the gamma duty mapping
// (see breath_pkg::gamma_map); FSM, level and timing are unaffected.
`timescale 1ns/1ps
module breath_ramp
  import breath_pkg::*;
#(
  parameter int PRESC      = DEF_PRESC,
  parameter int STEP       = DEF_STEP,
  parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       Enable,
  input  logic [7:0] Rate,
  input  logic [7:0] PwmCount,
  output logic [7:0] Duty,
  output logic       Dir,
  output logic       Peak
);

  localparam int         HW    = (HOLD_STEPS < 2) ? 1 : $clog2(HOLD_STEPS + 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);

  state_t        state, state_nxt;
  logic [7:0]    level, level_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          peak_nxt;
  logic          run;
  logic          step;
  logic          hold_done;

  assign run = Enable && (Rate != 8'd0);

  tick_gen #(
    .PRESC (PRESC)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .run      (run),
    .Rate     (Rate),
    .step     (step)
  );

  // Compared as "count after this step >= HOLD_STEPS" so HOLD_STEPS = 0
  // leaves the hold state on the first step event.
  assign hold_done = (int'(hold_cnt) + 1) >= HOLD_STEPS;

  assign Dir = (state == RISE) || (state == HOLD_HI);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    hold_nxt  = hold_cnt;
    peak_nxt  = 1'b0;
    if (step) begin
      case (state)
        RISE: begin
          // 9-bit sum so a large STEP cannot wrap past 255.
          if (({1'b0, level} + STEP9) >= 9'd255) begin
            level_nxt = 8'd255;
            state_nxt = HOLD_HI;
            peak_nxt  = 1'b1;
          end else begin
            level_nxt = level + STEP8;
          end
        end
        HOLD_HI: begin
          if (hold_done) begin
            hold_nxt  = '0;
            state_nxt = FALL;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        FALL: begin
          if (level <= STEP8) begin
            level_nxt = 8'd0;
            state_nxt = HOLD_LO;
          end else begin
            level_nxt = level - STEP8;
          end
        end
        HOLD_LO: begin
          if (hold_done) begin
            hold_nxt  = '0;
            state_nxt = RISE;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= HOLD_LO;
      level    <= 8'd0;
      hold_cnt <= '0;
      Peak     <= 1'b0;
      Duty     <= 8'd0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      hold_cnt <= hold_nxt;
      Peak     <= peak_nxt;
      // Reload on the last count of the PWM period; new value is live from 0.
      if (PwmCount == 8'hFF)
        Duty <= gamma_map(level);
    end
  end

endmodule

// File: doc/breath_ramp.md
# breath_ramp

Upstream stage of the LED fade datapath: generates the 8-bit duty value that the 8-bit PWM stage consumes. It produces a continuous rise–hold–fall–hold "breathing" triangle, with step rate selected from the toggle switches. The duty output is reloaded only at PWM period boundaries, so the PWM never sees a mid-period change.

## Interface
- PRESC, 50000: CLOCK_50 cycles per base tick (1 kHz at 50 MHz); legal range ≥ 2.
- STEP, 1: level increment/decrement per step event; legal range 1..255.
- HOLD_STEPS, 16: step events spent in each hold state; 0 means leave on the first step event.
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- Enable  input  1  high = ramp runs; low = state, level, and counters frozen.
- Rate  input  8  base ticks per step event (SW[7:0]); 0 = frozen, same as Enable low.
- PwmCount  input  8  free-running counter Q of the PWM stage.
- Duty  output  8  registered duty value to the PWM stage.
- Dir  output  1  1 in RISE/HOLD_HI, 0 in FALL/HOLD_LO.
- Peak  output  1  one-cycle pulse on entry to HOLD_HI.

## Operation
- Reset values:
  - Duty=0, Dir=0, Peak=0.
  - level=0, state=HOLD_LO.
  - Prescaler, rate counter, and hold counter all 0.
- Prescaler:
  - Counts 0..PRESC-1 while Enable=1 and Rate≠0.
  - Asserts tick in the cycle the count is PRESC-1, then wraps to 0.
- Rate counter:
  - Counts ticks 1..Rate; on the tick that reaches Rate, asserts step and clears.
  - If Rate is lowered below the current count, step fires on the next tick.
- FSM transitions, evaluated only on step:
  - RISE: if level+STEP ≥ 255 (9-bit compare), level=255, go to HOLD_HI, pulse Peak; else level+=STEP.
  - HOLD_HI: hold counter increments; on reaching HOLD_STEPS, clear it and go to FALL.
  - FALL: if level ≤ STEP, level=0, go to HOLD_LO; else level−=STEP.
  - HOLD_LO: mirrors HOLD_HI, then go to RISE.
- level never wraps; saturation is mandatory at both ends.
- Enable low or Rate=0:
  - All counters and state hold.
  - Duty still reloads at period boundaries (value unchanged).
- Duty reload: Duty ← map(level) in the cycle PwmCount==8'hFF, so the new value is active from PwmCount=0.

## Timing
- Step spacing is Rate×PRESC cycles; level updates one cycle after the step cycle.
- Level-to-Duty latency:
  - 1 cycle when level changes in the cycle before PwmCount==FF.
  - Otherwise up to 256 cycles.
- Peak is high for exactly one cycle: the first cycle with state=HOLD_HI.
- Dir changes in the same cycle as the state register.
- RESET_N low forces every reset value immediately, without a clock, including mid-ramp and mid-hold. Release takes effect at the next CLOCK_50 edge.

## Configuration
- BREATH_GAMMA_EN defined:
  - map(level) = (level×level + level) >> 8, with a 16-bit intermediate.
  - Gives 0→0, 64→16, 128→64, 192→144, 255→255; perceptually linear fade.
- BREATH_GAMMA_EN undefined: map(level) = level; no multiplier is synthesized.
- The setting does not affect FSM, level, Peak, Dir, or any timing.

## Structure
- Shared package breath_pkg:
  - State enum typedef: HOLD_LO, RISE, HOLD_HI, FALL.
  - Default constants: PRESC, STEP, HOLD_STEPS.
  - Gamma-map function.
- Sub-module tick_gen: prescaler plus rate counter, outputs step. Ports: CLOCK_50, RESET_N, run (Enable & Rate≠0), Rate, step.
- Top of breath_ramp holds the FSM, level register, and Duty register.

## Test plan
All scenarios use PRESC=4, STEP=64, HOLD_STEPS=2, gamma off, and PwmCount held at 8'hFF unless stated.
- **Reset:** hold RESET_N=0 → Duty=0, Dir=0, Peak=0, state=HOLD_LO; no activity with Enable=1 while in reset.
- **Full cycle:** Enable=1, Rate=1 →
  - After 2 holds, level steps every 4 cycles: 64, 128, 192, 255.
  - One Peak pulse, 2 holds, then 191, 127, 63, 0, HOLD_LO, repeat.
- **Freeze:** Rate=0 at level 128 for 100 cycles → level, state, and Duty stay 128; restoring Rate=1 resumes with level 192.
- **Boundary reload:** PwmCount free-running from 0 → Duty changes only in the cycle after PwmCount==FF; never mid-count.
- **Reset mid-ramp:** pulse RESET_N low for 3 ns at level 192 with no clock edge → Duty=0 immediately; ramp restarts from HOLD_LO.
- **Gamma:** with BREATH_GAMMA_EN, levels 64/128/192/255 → Duty 16/64/144/255.
